// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default sizing for the register-file write arbiter and its
// busy-register scoreboard.
package regfile_write_arbiter_pkg;

   localparam int DEFAULT_DATA_WIDTH   = 64;
   localparam int DEFAULT_ADDR_WIDTH   = 5;
   localparam int DEFAULT_REG_DEPTH    = 32;
   localparam int DEFAULT_STARVE_LIMIT = 4;

   typedef enum logic {
      ST_A_PRIO = 1'b0,
      ST_B_PRIO = 1'b1
   } arb_state_e;

   // Width of a counter that must be able to hold the value 'limit'.
   function automatic int starve_cnt_width(input int limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the arbiter's request, hazard-check and register-file write signals;
// the master side is the requesters/pipeline, the slave side is the arbiter.
interface regfile_write_arbiter_if
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);
   logic                  a_valid;
   logic [ADDR_WIDTH-1:0] a_addr;
   logic [DATA_WIDTH-1:0] a_data;
   logic                  a_ready;
   logic                  b_valid;
   logic [ADDR_WIDTH-1:0] b_addr;
   logic [DATA_WIDTH-1:0] b_data;
   logic                  b_ready;
   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_addr;
   logic [ADDR_WIDTH-1:0] rs1_addr;
   logic [ADDR_WIDTH-1:0] rs2_addr;
   logic                  hazard;
   logic                  write_en;
   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;

   modport master (
      output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
             issue_valid, issue_addr, rs1_addr, rs2_addr,
      input  a_ready, b_ready, hazard, write_en, write_addr, write_data
   );

   modport slave (
      input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
             issue_valid, issue_addr, rs1_addr, rs2_addr,
      output a_ready, b_ready, hazard, write_en, write_addr, write_data
   );
endinterface

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register, set on issue of
// a long-latency op and cleared when that unit writes back; x0 is never busy.
module regfile_scoreboard
   import regfile_write_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter int REG_DEPTH  = DEFAULT_REG_DEPTH
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_set_valid,
   input  logic [ADDR_WIDTH-1:0] i_set_addr,
   input  logic                  i_clr_valid,
   input  logic [ADDR_WIDTH-1:0] i_clr_addr,
   input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
   input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
   output logic                  o_hazard
);

   logic [REG_DEPTH-1:0] busy_q;
   logic [REG_DEPTH-1:0] busy_d;
   logic [REG_DEPTH-1:0] hit1;
   logic [REG_DEPTH-1:0] hit2;

   generate
      for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_bit
         if (gi == 0) begin : g_zero
            assign busy_d[gi] = 1'b0;
         end else begin : g_reg
            // Set is ORed after the clear so an issue racing a writeback wins.
            assign busy_d[gi] = (i_set_valid && (i_set_addr == ADDR_WIDTH'(gi)))
                              | (busy_q[gi] && !(i_clr_valid && (i_clr_addr == ADDR_WIDTH'(gi))));
         end
         assign hit1[gi] = busy_q[gi] && (i_rs1_addr == ADDR_WIDTH'(gi));
         assign hit2[gi] = busy_q[gi] && (i_rs2_addr == ADDR_WIDTH'(gi));
      end
   endgenerate

   assign o_hazard = (|hit1) | (|hit2);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter with starvation-forced priority swap,
// a registered write port and a busy-register hazard scoreboard.
module regfile_write_arbiter
   import regfile_write_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
   parameter int REG_DEPTH    = DEFAULT_REG_DEPTH,
   parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_a_valid,
   input  logic [ADDR_WIDTH-1:0] i_a_addr,
   input  logic [DATA_WIDTH-1:0] i_a_data,
   output logic                  o_a_ready,
   input  logic                  i_b_valid,
   input  logic [ADDR_WIDTH-1:0] i_b_addr,
   input  logic [DATA_WIDTH-1:0] i_b_data,
   output logic                  o_b_ready,
   input  logic                  i_issue_valid,
   input  logic [ADDR_WIDTH-1:0] i_issue_addr,
   input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
   input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
   output logic                  o_hazard,
   output logic                  o_write_en,
   output logic [ADDR_WIDTH-1:0] o_write_addr,
   output logic [DATA_WIDTH-1:0] o_write_data
);

   localparam int CNT_W = starve_cnt_width(STARVE_LIMIT);

   arb_state_e            state_q, state_d;
   logic [CNT_W-1:0]      starve_q, starve_d;
   logic                  a_xfer;
   logic                  b_xfer;
   logic                  b_blocked;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

   always_comb begin
      o_a_ready = 1'b0;
      o_b_ready = 1'b0;
      if (!i_rst) begin
         if (state_q == ST_A_PRIO) begin
            o_a_ready = 1'b1;
            o_b_ready = ~i_a_valid;
         end else begin
            o_b_ready = 1'b1;
            o_a_ready = ~i_b_valid;
         end
      end
   end

   assign a_xfer    = i_a_valid & o_a_ready;
   assign b_xfer    = i_b_valid & o_b_ready;
   assign b_blocked = (state_q == ST_A_PRIO) & i_b_valid & ~o_b_ready;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      if (b_xfer) begin
         starve_d = '0;
      end else if (b_blocked) begin
         starve_d = starve_q + CNT_W'(1);
      end
      case (state_q)
         ST_A_PRIO: if (b_blocked && (starve_q == CNT_W'(STARVE_LIMIT - 1))) state_d = ST_B_PRIO;
         ST_B_PRIO: if (b_xfer) state_d = ST_A_PRIO;
         default:   state_d = ST_A_PRIO;
      endcase
   end

   // Address and data follow every transfer, including x0 writes; only the enable is suppressed.
   always_comb begin
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      if (a_xfer) begin
         wr_en_d   = (i_a_addr != '0);
         wr_addr_d = i_a_addr;
         wr_data_d = i_a_data;
      end else if (b_xfer) begin
         wr_en_d   = (i_b_addr != '0);
         wr_addr_d = i_b_addr;
         wr_data_d = i_b_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_A_PRIO;
         starve_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign o_write_en   = wr_en_q;
   assign o_write_addr = wr_addr_q;
   assign o_write_data = wr_data_q;

   regfile_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .REG_DEPTH  (REG_DEPTH)
   ) u_scoreboard (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_set_valid (i_issue_valid),
      .i_set_addr  (i_issue_addr),
      .i_clr_valid (b_xfer),
      .i_clr_addr  (i_b_addr),
      .i_rs1_addr  (i_rs1_addr),
      .i_rs2_addr  (i_rs2_addr),
      .o_hazard    (o_hazard)
   );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and random stimulus for regfile_write_arbiter; expectations come from a
// behavioural model and are checked by a separate monitor through a queue.
module tb_regfile_write_arbiter;
   import regfile_write_arbiter_pkg::*;

   localparam int DW = 64;
   localparam int AW = 5;
   localparam int RD = 32;
   localparam int SL = 4;

   logic clk;
   logic rst;

   regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   regfile_write_arbiter #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .REG_DEPTH    (RD),
      .STARVE_LIMIT (SL)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_a_valid     (bus.a_valid),
      .i_a_addr      (bus.a_addr),
      .i_a_data      (bus.a_data),
      .o_a_ready     (bus.a_ready),
      .i_b_valid     (bus.b_valid),
      .i_b_addr      (bus.b_addr),
      .i_b_data      (bus.b_data),
      .o_b_ready     (bus.b_ready),
      .i_issue_valid (bus.issue_valid),
      .i_issue_addr  (bus.issue_addr),
      .i_rs1_addr    (bus.rs1_addr),
      .i_rs2_addr    (bus.rs2_addr),
      .o_hazard      (bus.hazard),
      .o_write_en    (bus.write_en),
      .o_write_addr  (bus.write_addr),
      .o_write_data  (bus.write_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          rst;
      bit          av;
      logic [AW-1:0] aa;
      logic [DW-1:0] ad;
      bit          bv;
      logic [AW-1:0] ba;
      logic [DW-1:0] bd;
      bit          iv;
      logic [AW-1:0] ia;
      logic [AW-1:0] r1;
      logic [AW-1:0] r2;
   } stim_t;

   typedef struct {
      int          cyc;
      bit          chk;
      bit          chk_data;
      bit          ra;
      bit          rb;
      bit          hz;
      bit          en;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   // Reference model: who wins, how long B has waited, which registers are pending.
   bit            m_init      = 1'b0;
   bit            m_b_favoured = 1'b0;
   int            m_waited    = 0;
   bit            m_busy[RD];
   bit            m_en        = 1'b0;
   bit            m_data_ok   = 1'b0;
   logic [AW-1:0] m_addr      = '0;
   logic [DW-1:0] m_data      = '0;

   function automatic stim_t idle();
      stim_t s;
      s.rst = 0; s.av = 0; s.aa = '0; s.ad = '0;
      s.bv = 0; s.ba = '0; s.bd = '0;
      s.iv = 0; s.ia = '0; s.r1 = '0; s.r2 = '0;
      return s;
   endfunction

   task automatic step(input stim_t s);
      exp_t e;
      bit a_acc, b_acc;
      rst             = s.rst;
      bus.a_valid     = s.av;  bus.a_addr = s.aa;  bus.a_data = s.ad;
      bus.b_valid     = s.bv;  bus.b_addr = s.ba;  bus.b_data = s.bd;
      bus.issue_valid = s.iv;  bus.issue_addr = s.ia;
      bus.rs1_addr    = s.r1;  bus.rs2_addr = s.r2;

      e.cyc      = cyc;
      e.chk      = m_init;
      e.chk_data = m_init && m_data_ok;
      e.ra       = s.rst ? 1'b0 : (m_b_favoured ? !s.bv : 1'b1);
      e.rb       = s.rst ? 1'b0 : (m_b_favoured ? 1'b1 : !s.av);
      e.hz       = m_busy[s.r1] || m_busy[s.r2];
      e.en       = m_en;
      e.addr     = m_addr;
      e.data     = m_data;
      exp_q.push_back(e);

      if (s.rst) begin
         m_init = 1'b1; m_b_favoured = 1'b0; m_waited = 0;
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_en = 1'b0; m_addr = '0; m_data = '0; m_data_ok = 1'b1;
      end else begin
         a_acc = s.av && e.ra;
         b_acc = s.bv && e.rb;
         m_en  = 1'b0;
         if (a_acc || b_acc) begin
            m_addr    = a_acc ? s.aa : s.ba;
            m_data    = a_acc ? s.ad : s.bd;
            m_en      = (m_addr != 0);
            m_data_ok = m_en;
         end
         if (b_acc) begin
            m_waited = 0;
            m_b_favoured = 1'b0;
            m_busy[s.ba] = 1'b0;
         end else if (s.bv && !m_b_favoured) begin
            m_waited++;
            if (m_waited == SL) m_b_favoured = 1'b1;
         end
         if (s.iv && s.ia != 0) m_busy[s.ia] = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string nm, input int c, input logic [DW-1:0] act, input logic [DW-1:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, want);
      end
   endtask

   // Monitor: each negedge compares the DUT against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("a_ready", e.cyc, DW'(bus.a_ready), DW'(e.ra));
            chk("b_ready", e.cyc, DW'(bus.b_ready), DW'(e.rb));
            if (e.chk) begin
               chk("hazard",   e.cyc, DW'(bus.hazard),   DW'(e.hz));
               chk("write_en", e.cyc, DW'(bus.write_en), DW'(e.en));
               if (e.chk_data) begin
                  chk("write_addr", e.cyc, DW'(bus.write_addr), DW'(e.addr));
                  chk("write_data", e.cyc, bus.write_data, e.data);
               end
               if (bus.write_en === 1'b1)
                  $display("cycle %0d: write x%0d <= %0h", e.cyc, bus.write_addr, bus.write_data);
            end
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1'b1;
      bus.a_valid = 0; bus.a_addr = '0; bus.a_data = '0;
      bus.b_valid = 0; bus.b_addr = '0; bus.b_data = '0;
      bus.issue_valid = 0; bus.issue_addr = '0;
      bus.rs1_addr = '0; bus.rs2_addr = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      @(posedge clk);
      #1;

      s = idle(); s.rst = 1;
      step(s); step(s);

      // Release from reset with both requesters valid: A must win.
      s = idle(); s.av = 1; s.aa = 5; s.ad = 64'h11; s.bv = 1; s.ba = 12; s.bd = 64'h22;
      step(s);
      step(idle());

      // Continuous contention: B is forced through on the fifth cycle.
      s = idle(); s.rst = 1; step(s);
      for (int i = 0; i < 7; i++) begin
         s = idle(); s.av = 1; s.aa = AW'(i + 1); s.ad = DW'(100 + i);
         s.bv = 1; s.ba = 20; s.bd = 64'hB0B0;
         step(s);
      end
      step(idle());

      // Write to x0 handshakes but never enables the write.
      s = idle(); s.av = 1; s.aa = 0; s.ad = 64'hFF; step(s);
      step(idle());

      // Hazard lifetime of an issued register.
      s = idle(); s.iv = 1; s.ia = 7; s.r1 = 7; step(s);
      s = idle(); s.r1 = 7; step(s);
      s = idle(); s.r1 = 7; s.bv = 1; s.ba = 7; s.bd = 64'h77; step(s);
      s = idle(); s.r1 = 7; step(s);

      // Issue and writeback to the same register in one cycle: still busy.
      s = idle(); s.iv = 1; s.ia = 9; s.bv = 1; s.ba = 9; s.bd = 64'h99; step(s);
      s = idle(); s.r2 = 9; step(s);

      // Reset while B is favoured and x3 is pending.
      s = idle(); s.iv = 1; s.ia = 3; step(s);
      for (int i = 0; i < SL; i++) begin
         s = idle(); s.av = 1; s.aa = 4; s.ad = DW'(i); s.bv = 1; s.ba = 6; s.bd = 64'h66; s.r1 = 3;
         step(s);
      end
      s = idle(); s.rst = 1; s.av = 1; s.aa = 4; s.bv = 1; s.ba = 6; s.r1 = 3; step(s);
      s = idle(); s.r1 = 3; s.av = 1; s.aa = 8; s.ad = 64'h8; s.bv = 1; s.ba = 6; step(s);
      step(idle());

      for (int n = 0; n < 1500; n++) begin
         s.rst = ($urandom_range(0, 99) == 0);
         s.av  = $urandom_range(0, 1) != 0;
         s.aa  = AW'($urandom_range(0, RD - 1));
         s.ad  = {$urandom, $urandom};
         s.bv  = $urandom_range(0, 9) < 6;
         s.ba  = AW'($urandom_range(0, RD - 1));
         s.bd  = {$urandom, $urandom};
         s.iv  = $urandom_range(0, 9) < 3;
         s.ia  = AW'($urandom_range(0, RD - 1));
         s.r1  = AW'($urandom_range(0, RD - 1));
         s.r2  = AW'($urandom_range(0, RD - 1));
         step(s);
      end
      step(idle());

      for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
